// File: rtl/mp_pkg.sv
// Shared sizing constants for the iterative multi-precision adder/subtractor.
package mp_pkg;
    localparam int N  = 1027;
    localparam int W  = 64;
    localparam int NC = 17;
    localparam int P  = NC * W;
    localparam int CW = $clog2(NC + 1);
endpackage

// File: rtl/mp_chunk_add.sv
// One W-bit slice of the ripple: s/cout from a + b + cin.
module mp_chunk_add
    import mp_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mp_adder.sv
// 1027-bit add/subtract, one 64-bit chunk per clock; subtraction is a + ~b + 1.
module mp_adder
    import mp_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N:0]   result,
    output logic         done
);

    logic [P-1:0]  opA_q, opA_d;
    logic [P-1:0]  opB_q, opB_d;
    logic [P-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [P-1:0]  bExt;
    logic [W-1:0]  chunkSum;
    logic          chunkCout;

    assign bExt = {{(P-N){1'b0}}, in_b};

    mp_chunk_add u_chunk (
        .a    (opA_q[W-1:0]),
        .b    (opB_q[W-1:0]),
        .cin  (carry_q),
        .s    (chunkSum),
        .cout (chunkCout)
    );

    // A new start always wins, even over a busy or completing operation.
    always_comb begin
        opA_d   = opA_q;
        opB_d   = opB_q;
        res_d   = res_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (start) begin
            opA_d   = {{(P-N){1'b0}}, in_a};
            opB_d   = subtract ? ~bExt : bExt;
            carry_d = subtract;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else if (busy_q) begin
            opA_d   = {{W{1'b0}}, opA_q[P-1:W]};
            opB_d   = {{W{1'b0}}, opB_q[P-1:W]};
            res_d   = {chunkSum, res_q[P-1:W]};
            carry_d = chunkCout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NC - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            opA_q   <= '0;
            opB_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign result = res_q[N:0];
    assign done   = done_q;

endmodule

// File: tb/tb_mp_adder.sv
// Scoreboard bench for mp_adder: stimulus pushes expected results, a monitor checks on done.
module tb_mp_adder;
    import mp_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         subtract;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic [N:0]   result;
    logic         done;

    typedef struct {
        logic [N:0] value;
        int         captureCycle;
    } expect_t;

    expect_t sbQueue[$];
    int      cycle  = 0;
    int      checks = 0;
    int      passes = 0;
    logic    prevDone = 1'b0;

    mp_adder dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .in_a     (inA),
        .in_b     (inB),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    function automatic logic [N:0] refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        logic [N:0] ea;
        logic [N:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return sub ? (ea - eb) : (ea + eb);
    endfunction

    function automatic logic [N-1:0] randOperand();
        logic [N-1:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        v[N-1:1024] = 3'($urandom);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [N:0] actual, input logic [N:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
                      name, actual[N:N-63], actual[127:0], expected[N:N-63], expected[127:0]);
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // A start over a still-pending request aborts it, so its expectation is dropped.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        expect_t e;
        @(negedge clk);
        #1;
        if (sbQueue.size() > 0) sbQueue.delete(sbQueue.size() - 1);
        inA      = a;
        inB      = b;
        subtract = sub;
        start    = 1'b1;
        e.value        = refModel(a, b, sub);
        e.captureCycle = cycle + 1;
        sbQueue.push_back(e);
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (sbQueue.size() > 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sbQueue.size() > 0) begin
            checks++;
            $display("[TB] FAIL timeout: %0d requests still pending after %0d cycles", sbQueue.size(), budget);
            sbQueue.delete();
        end
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (done && !prevDone) begin
            if (sbQueue.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, expected no completion", cycle);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("result", result, e.value);
                checkInt("latency", cycle - e.captureCycle, NC);
            end
        end
        prevDone = done;
    end

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N:0]   expectVal;

        resetn   = 1'b0;
        start    = 1'b0;
        subtract = 1'b0;
        inA      = '0;
        inB      = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetResult", result, '0);
        checkBit("resetDone", done, 1'b0);
        resetn = 1'b1;

        applyStimulus(N'(12), N'(13), 1'b0);
        waitDone(40);
        repeat (5) @(negedge clk);
        checkBit("doneHold", done, 1'b1);
        expectVal = (N+1)'(25);
        checkOutput("resultHold", result, expectVal);

        for (int i = 0; i < 6; i++) begin
            a = randOperand();
            b = randOperand();
            a[N-1] = 1'b1;
            b[N-1] = 1'b1;
            applyStimulus(a, b, 1'b0);
            waitDone(40);
            checkBit("addCarryOut", result[N], 1'b1);
        end

        applyStimulus(N'(2), N'(2), 1'b1);
        waitDone(40);
        checkOutput("subEqualZero", result, '0);

        a = randOperand();
        b = randOperand();
        a[N-1:N-15] = 15'h53f5;
        b[N-1:N-15] = 15'h4a6e;
        applyStimulus(a, b, 1'b1);
        waitDone(40);
        checkBit("subNoBorrow", result[N], 1'b0);

        applyStimulus(N'(1), N'(2), 1'b1);
        waitDone(40);
        checkOutput("subAllOnes", result, '1);

        a = '1;
        applyStimulus(a, a, 1'b0);
        waitDone(40);
        expectVal = '1;
        expectVal[0] = 1'b0;
        checkOutput("addMaxMax", result, expectVal);

        // Abort mid-operation; only the second request may complete.
        applyStimulus(randOperand(), randOperand(), 1'b0);
        repeat (6) @(negedge clk);
        applyStimulus(randOperand(), randOperand(), 1'b1);
        checkBit("doneLowAfterAbort", done, 1'b0);
        waitDone(40);

        applyStimulus(randOperand(), randOperand(), 1'b0);
        repeat (15) @(negedge clk);
        applyStimulus(randOperand(), randOperand(), 1'b0);
        checkBit("doneLowOnCompletionRestart", done, 1'b0);
        waitDone(40);

        applyStimulus(randOperand(), randOperand(), 1'b1);
        inA      = randOperand();
        inB      = randOperand();
        subtract = 1'b0;
        waitDone(40);

        applyStimulus(randOperand(), randOperand(), 1'b0);
        repeat (5) @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midResetResult", result, '0);
        checkBit("midResetDone", done, 1'b0);
        sbQueue.delete();
        @(negedge clk);
        #1;
        resetn = 1'b1;
        applyStimulus(randOperand(), randOperand(), 1'b1);
        waitDone(40);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(randOperand(), randOperand(), 1'($urandom));
            waitDone(40);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
